// File: rtl/shift_tx.sv
// shift_tx: frames a parallel word into start/data/parity/stop bits on a serial line, one word per handshake.
module shift_tx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [BW-1:0] bit_idx, nbit;
  logic [WIDTH-1:0] shreg, nshreg;
  logic par, npar, bit_end, accept;
  logic sdo_d, busy_d, ready_d, done_d;
  assign bit_end = cnt == CNT_MAX;
  assign accept  = load && ready;
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = accept ? START : IDLE;
      START:   nstate = bit_end ? DATA : START;
      DATA:    nstate = (bit_end && bit_idx == BIT_MAX) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     nstate = bit_end ? STOP : PAR;
      STOP:    nstate = bit_end ? IDLE : STOP;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    ncnt   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    nbit   = (state == DATA && bit_end) ? (bit_idx == BIT_MAX ? '0 : bit_idx + 1'b1) : bit_idx;
    nshreg = accept ? data : (state == DATA && bit_end) ? shreg >> 1 : shreg;
    npar   = accept ? ^data : par;
  end
  // outputs are computed from next-state values so they register in step with the state
  always_comb begin
    sdo_d   = nstate == START ? 1'b0 : nstate == DATA ? nshreg[0] : nstate == PAR ? npar : 1'b1;
    busy_d  = nstate != IDLE;
    ready_d = nstate == IDLE;
    done_d  = nstate == STOP && ncnt == CNT_MAX;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      cnt     <= ncnt;
      bit_idx <= nbit;
      shreg   <= nshreg;
      par     <= npar;
    end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      sdo   <= 1'b1;
      busy  <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      sdo   <= sdo_d;
      busy  <= busy_d;
      ready <= ready_d;
      done  <= done_d;
    end
endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: table-driven frame checks on three shift_tx configurations plus reset corner cases.
module tb_shift_tx;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [2:0] load_w = 3'b000;
  logic [2:0] sdo_w, busy_w, ready_w, done_w;
  logic [7:0] data_w [3];
  int checks = 0;
  int fails = 0;
  typedef struct {
    int          inst;
    logic [7:0]  d;
    logic        hold;
    int          nb;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl [9];
  always #5 clk = ~clk;
  shift_tx #(.WIDTH(8), .DIV(4), .PARITY(0)) u0 (.clk(clk), .clr(clr), .data(data_w[0]), .load(load_w[0]),
    .ready(ready_w[0]), .sdo(sdo_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  shift_tx #(.WIDTH(8), .DIV(4), .PARITY(1)) u1 (.clk(clk), .clr(clr), .data(data_w[1]), .load(load_w[1]),
    .ready(ready_w[1]), .sdo(sdo_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  shift_tx #(.WIDTH(8), .DIV(1), .PARITY(0)) u2 (.clk(clk), .clr(clr), .data(data_w[2]), .load(load_w[2]),
    .ready(ready_w[2]), .sdo(sdo_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  function automatic logic [3:0] st(int i);
    return {sdo_w[i], busy_w[i], ready_w[i], done_w[i]};
  endfunction
  task automatic check(string name, logic [3:0] got, logic [3:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: sdo/busy/ready/done got %b want %b", name, got, want);
    end
  endtask
  // drives one word at a negedge and checks every cycle of its frame plus the idle cycle after it
  task automatic run_frame(int i, logic [7:0] d, logic hold, int nb, logic [10:0] exp);
    int dv;
    dv = (i == 2) ? 1 : 4;
    check($sformatf("inst%0d ready before %h", i, d), st(i), 4'b1010);
    data_w[i] = d;
    load_w[i] = 1'b1;
    @(negedge clk);
    if (hold) data_w[i] = 8'hFF;
    else load_w[i] = 1'b0;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < dv; c++) begin
        check($sformatf("inst%0d word %h bit %0d cyc %0d", i, d, k, c), st(i),
              {exp[k], 1'b1, 1'b0, (k == nb - 1 && c == dv - 1)});
        @(negedge clk);
      end
    check($sformatf("inst%0d idle after %h", i, d), st(i), 4'b1010);
    load_w[i] = 1'b0;
  endtask
  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 10, 11'b0_1_10100101_0};
    tbl[1] = '{0, 8'h3C, 1'b1, 10, 11'b0_1_00111100_0};
    tbl[2] = '{0, 8'h00, 1'b0, 10, 11'b0_1_00000000_0};
    tbl[3] = '{1, 8'h07, 1'b0, 11, 11'b1_1_00000111_0};
    tbl[4] = '{1, 8'hA5, 1'b0, 11, 11'b1_0_10100101_0};
    tbl[5] = '{1, 8'hFF, 1'b0, 11, 11'b1_0_11111111_0};
    tbl[6] = '{2, 8'h01, 1'b1, 10, 11'b0_1_00000001_0};
    tbl[7] = '{2, 8'h80, 1'b1, 10, 11'b0_1_10000000_0};
    tbl[8] = '{2, 8'h55, 1'b0, 10, 11'b0_1_01010101_0};
    for (int i = 0; i < 3; i++) data_w[i] = 8'hAA;
    #1 clr = 1'b0;
    load_w = 3'b111;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("inst%0d held in reset", i), st(i), 4'b1010);
    end
    clr = 1'b1;
    load_w = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("inst%0d idle after reset", i), st(i), 4'b1010);
    for (int n = 0; n < 9; n++) run_frame(tbl[n].inst, tbl[n].d, tbl[n].hold, tbl[n].nb, tbl[n].exp);
    data_w[0] = 8'h00;
    load_w[0] = 1'b1;
    @(negedge clk);
    load_w[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("midframe data bit3", st(0), 4'b0100);
    #2 clr = 1'b0;
    #1 check("async clear mid-frame", st(0), 4'b1010);
    @(negedge clk);
    check("held in mid-frame clear", st(0), 4'b1010);
    clr = 1'b1;
    @(negedge clk);
    check("idle after mid-frame clear", st(0), 4'b1010);
    run_frame(0, 8'h55, 1'b0, 10, 11'b0_1_01010101_0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
